// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over req/ack, holds it
// for the decoder until retire, then selects the next PC (jump > taken branch > pc+4).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] retired_count,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = signimm << 2;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // Handshake: imem_req is held high for every FETCH cycle with imem_addr = pc; the
  // word is taken on the first cycle imem_ack is high (rdata valid that same cycle).
  // An ack seen in any other state is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (retire) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = (state_q == S_EXEC);
  assign pc            = pc_q;
  assign pcplus4       = pc_plus4;
  assign retired_count = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, wait states, stalls,
// branches, jumps, PC wrap and reset during fetch.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_FETCH = 2'd1;
  localparam logic [1:0]  ST_EXEC  = 2'd2;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        retire;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] retired_count;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_count;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pcplus4(pcplus4),
    .retire(retire), .branch(branch), .zero(zero), .jump(jump),
    .signimm(signimm), .retired_count(retired_count), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic do_fetch(input logic [31:0] word);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req got %b exp 1", imem_req);
    end
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic do_retire(input logic br, input logic z, input logic j, input logic [31:0] imm);
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL retire_in_exec got %b exp 1", instr_valid);
    end
    branch = br; zero = z; jump = j; signimm = imm; retire = 1'b1;
    tick();
    branch = 1'b0; zero = 1'b0; jump = 1'b0; signimm = 32'h0; retire = 1'b0;
    model_count = model_count + 32'd1;
  endtask

  // Reach an arbitrary PC with one taken branch; signimm<<2 only keeps 30 bits anyway.
  task automatic goto_pc(input logic [31:0] target);
    do_fetch(32'h1000_0000);
    do_retire(1'b1, 1'b1, 1'b0, (target - model_pc - 32'd4) >> 2);
    model_pc = target;
    checks++;
    if (imem_addr !== target) begin
      errors++;
      $display("FAIL goto_addr got %h exp %h", imem_addr, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, RST_PC); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", imem_addr, RST_PC); end
    checks++; if (pcplus4 !== 32'h104) begin errors++; $display("FAIL rst_pcplus4 got %h exp 104", pcplus4); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", imem_req, instr_valid); end
    checks++; if (retired_count !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", retired_count); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", state_o, ST_IDLE); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2000_0000; retire = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_addr = RST_PC + 32'(4 * k);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL seq_fetch%0d got %b %h exp 1 %h", k, imem_req, imem_addr, exp_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_exec%0d got %b%b exp 10", k, instr_valid, imem_req); end
      tick();
    end
    imem_ack = 1'b0; retire = 1'b0; imem_rdata = 32'h0;
    checks++; if (retired_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", retired_count); end
    checks++; if (imem_addr !== 32'h10C) begin errors++; $display("FAIL seq_next got %h exp 10c", imem_addr); end
    model_pc = 32'h10C; model_count = 32'd3;
  endtask

  task automatic test_wait_ack();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || instr_valid !== 1'b0) begin
        errors++; $display("FAIL wait_hold%0d got %b %h %b exp 1 10c 0", i, imem_req, imem_addr, instr_valid);
      end
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL wait_valid got %b%b exp 10", instr_valid, imem_req); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_instr got %h exp deadbeef", instr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1; imem_rdata = $urandom; jump = 1'b1; branch = 1'b1; zero = 1'b1;
      signimm = $urandom;
      tick();
      checks++; if (instr !== 32'hDEAD_BEEF || pc !== 32'h10C || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall%0d got %h %h %b%b exp deadbeef 10c 10", i, instr, pc, instr_valid, imem_req);
      end
    end
    imem_ack = 1'b0; imem_rdata = 32'h0; jump = 1'b0; branch = 1'b0; zero = 1'b0; signimm = 32'h0;
    do_retire(1'b0, 1'b0, 1'b0, 32'h0);
    model_pc = 32'h110;
    checks++; if (imem_addr !== 32'h110 || retired_count !== 32'd4) begin errors++; $display("FAIL stall_seq got %h %0d exp 110 4", imem_addr, retired_count); end
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    do_fetch(32'h1000_FFFE);
    do_retire(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'h1C) begin errors++; $display("FAIL beq_taken got %h exp 1c", imem_addr); end
    model_pc = 32'h1C;
    goto_pc(32'h20);
    do_fetch(32'h1000_FFFE);
    do_retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'h24) begin errors++; $display("FAIL beq_not_taken got %h exp 24", imem_addr); end
    model_pc = 32'h24;
  endtask

  task automatic test_jump();
    goto_pc(32'h1000_0000);
    do_fetch(32'h0800_0040);
    checks++; if (instr !== 32'h0800_0040) begin errors++; $display("FAIL j_instr got %h exp 08000040", instr); end
    do_retire(1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL j_target got %h exp 10000100", pc); end
    do_fetch(32'h0800_0040);
    do_retire(1'b1, 1'b1, 1'b1, 32'h5);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL j_priority got %h exp 10000100", pc); end
    model_pc = 32'h1000_0100;
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    checks++; if (pcplus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h exp 0", pcplus4); end
    do_fetch(32'h0);
    do_retire(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc got %h %b exp 0 1", imem_addr, imem_req); end
    checks++; if (retired_count !== model_count) begin errors++; $display("FAIL wrap_count got %0d exp %0d", retired_count, model_count); end
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    checks++; if (state_o !== ST_IDLE || instr !== 32'h0 || retired_count !== 32'h0) begin
      errors++; $display("FAIL rfetch_idle got %0d %h %0d exp 0 0 0", state_o, instr, retired_count);
    end
    reset = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    checks++; if (state_o !== ST_FETCH || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL rfetch_late_ack got %0d %b %h exp 1 0 0", state_o, instr_valid, instr);
    end
    checks++; if (imem_addr !== RST_PC || imem_req !== 1'b1) begin errors++; $display("FAIL rfetch_restart got %h %b exp 100 1", imem_addr, imem_req); end
    tick();
    checks++; if (state_o !== ST_FETCH || retired_count !== 32'h0) begin errors++; $display("FAIL rfetch_hold got %0d %0d exp 1 0", state_o, retired_count); end
    do_fetch(32'h1234_5678);
    checks++; if (state_o !== ST_EXEC || instr !== 32'h1234_5678) begin errors++; $display("FAIL rfetch_exec got %0d %h exp 2 12345678", state_o, instr); end
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; retire = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; signimm = 32'h0;
    model_pc = RST_PC; model_count = 32'h0;
    test_reset();
    test_sequential();
    test_wait_ack();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
